// File: rtl/spi_pkg.sv
// Definitions shared by the SPI transmit and receive sides: FSM states, default word width,
// and which serial clock edge samples data.
package spi_pkg;

  typedef enum logic [1:0] {
    StWaitIdle,
    StIdle,
    StRecv
  } rx_state_e;

  localparam int unsigned DefaultWidth = 16;

  // Mode 0: data is sampled on the rising serial clock edge.
  localparam logic SampleOnRise = 1'b1;

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchronizer for one asynchronous input bit, with a selectable reset value.
module sync_bit #(
  parameter int unsigned Stages   = 2,
  parameter logic        ResetVal = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [Stages-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {Stages{ResetVal}};
    end else begin
      sync_q <= {sync_q[Stages-2:0], d_i};
    end
  end

  assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/spi_frame_receiver.sv
// SPI mode-0 frame receiver: oversamples cs/sclk/sdo on the system clock, recovers MSB-first
// words, flags bad bit counts and presents results through a one-entry ready/valid register.
module spi_frame_receiver
  import spi_pkg::*;
#(
  parameter int unsigned Width      = DefaultWidth,
  parameter int unsigned SyncStages = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cs_i,
  input  logic             sclk_i,
  input  logic             sdo_i,
  output logic [Width-1:0] data_out_o,
  output logic             data_valid_o,
  input  logic             data_ready_i,
  output logic             frame_err_o,
  output logic             overrun_o,
  output logic             busy_o
);

  localparam int unsigned     CntW      = $clog2(Width + 2);
  localparam logic [CntW-1:0] CntFull   = CntW'(Width);
  localparam logic [CntW-1:0] CntSat    = CntW'(Width + 1);
  localparam int unsigned     FlushW    = $clog2(SyncStages + 2);
  localparam logic [FlushW-1:0] FlushDone = FlushW'(SyncStages + 1);

  logic cs_s, sclk_s, sdo_s;

  sync_bit #(.Stages(SyncStages), .ResetVal(1'b1)) u_sync_cs (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (cs_i),
    .q_o    (cs_s)
  );

  sync_bit #(.Stages(SyncStages), .ResetVal(1'b0)) u_sync_sclk (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (sclk_i),
    .q_o    (sclk_s)
  );

  sync_bit #(.Stages(SyncStages), .ResetVal(1'b0)) u_sync_sdo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (sdo_i),
    .q_o    (sdo_s)
  );

  // Registered edge strobes; sdo_q is delayed by the same amount so it pairs with sclk_rise_q.
  logic cs_last_q, sclk_last_q, sdo_q;
  logic cs_fall_q, cs_rise_q, sclk_rise_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cs_last_q   <= 1'b1;
      sclk_last_q <= 1'b0;
      sdo_q       <= 1'b0;
      cs_fall_q   <= 1'b0;
      cs_rise_q   <= 1'b0;
      sclk_rise_q <= 1'b0;
    end else begin
      cs_last_q   <= cs_s;
      sclk_last_q <= sclk_s;
      sdo_q       <= sdo_s;
      cs_fall_q   <= cs_last_q & ~cs_s;
      cs_rise_q   <= ~cs_last_q & cs_s;
      sclk_rise_q <= SampleOnRise ? (sclk_s & ~sclk_last_q) : (~sclk_s & sclk_last_q);
    end
  end

  rx_state_e        state_q;
  logic [Width-1:0] shreg_q, shreg_d;
  logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [FlushW-1:0] flush_cnt_q;
  logic [Width-1:0] data_out_q;
  logic             data_valid_q, frame_err_q, overrun_q;
  logic             drain;

  // Shift precedes close so a coincident sclk edge counts toward the frame.
  always_comb begin
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    if (sclk_rise_q) begin
      shreg_d = {shreg_q[Width-2:0], sdo_q};
      if (bit_cnt_q != CntSat) begin
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end
  end

  assign drain = data_valid_q & data_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StWaitIdle;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      flush_cnt_q  <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      if (drain) begin
        data_valid_q <= 1'b0;
      end
      unique case (state_q)
        // Wait out the reset value still flowing through the cs synchronizer and strobe flops,
        // so a frame already under way at release never looks like a fresh cs fall.
        StWaitIdle: begin
          if (flush_cnt_q != FlushDone) begin
            flush_cnt_q <= flush_cnt_q + 1'b1;
          end else if (cs_last_q) begin
            state_q <= StIdle;
          end
        end
        StIdle: begin
          if (cs_fall_q) begin
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            state_q   <= StRecv;
          end
        end
        StRecv: begin
          shreg_q   <= shreg_d;
          bit_cnt_q <= bit_cnt_d;
          if (cs_rise_q) begin
            state_q <= StIdle;
            if (bit_cnt_d != CntFull) begin
              frame_err_q <= 1'b1;
            end else if (!data_valid_q || data_ready_i) begin
              data_out_q   <= shreg_d;
              data_valid_q <= 1'b1;
            end else begin
              overrun_q <= 1'b1;
            end
          end
        end
        default: state_q <= StWaitIdle;
      endcase
    end
  end

  assign data_out_o   = data_out_q;
  assign data_valid_o = data_valid_q;
  assign frame_err_o  = frame_err_q;
  assign overrun_o    = overrun_q;
  assign busy_o       = (state_q == StRecv);

endmodule

// File: doc/spi_frame_receiver.md
# spi_frame_receiver

Receive side of the serial link driven by the counter block: accepts the `cs`/`sclk`/`sdo` triple and recovers each WIDTH-bit word, MSB first, sampled on rising `sclk` while `cs` is low (SPI mode 0). It oversamples all three lines on the system clock and flags malformed frames. Recovered words go out through a one-entry ready/valid holding register, so a downstream consumer can stall without corrupting the shift path.

## Interface
- `WIDTH`, default 16: bits per frame.
- `SYNC_STAGES`, default 2: synchronizer flops on each serial input, minimum 2.

- `clk`  in  1: system clock; all state is on its rising edge.
- `rst_n`  in  1: asynchronous reset, active low; release is synchronous to `clk`.
- `cs`  in  1: chip select, active low, asynchronous to `clk`.
- `sclk`  in  1: serial clock, asynchronous to `clk`.
- `sdo`  in  1: serial data from the transmitter.
- `data_out`  out  WIDTH: last completed word; valid while `data_valid` is high.
- `data_valid`  out  1: holding register full.
- `data_ready`  in  1: consumer accepts `data_out` on any `clk` edge where `data_valid && data_ready`.
- `frame_err`  out  1: one-cycle pulse when a frame ends with a bit count other than WIDTH.
- `overrun`  out  1: one-cycle pulse when a good frame is dropped because the holding register is full.
- `busy`  out  1: high while in RECV.

## Operation
- Each of `cs`, `sclk` and `sdo` passes through a SYNC_STAGES synchronizer of equal depth, so the synchronized `sdo` stays aligned with the synchronized `sclk`.
- Edge detect uses one extra flop per line: `sclk_rise`, `cs_fall` and `cs_rise` are single-cycle strobes.
- The FSM has three states.
  - WAIT_IDLE: reset state. Go to IDLE once synchronized `cs` is high, so a frame already in progress at reset release is discarded.
  - IDLE: on `cs_fall`, clear the shift register and `bit_cnt`, then go to RECV.
  - RECV: on `sclk_rise`, shift in `sdo` (`shreg <= {shreg[WIDTH-2:0], sdo}`) and increment `bit_cnt`. On `cs_rise`, close the frame and go to IDLE.
- `bit_cnt` is $clog2(WIDTH+2) bits wide and saturates at WIDTH+1. Shifting continues past WIDTH, but any count other than WIDTH is an error.
- Frame close rules:
  - `bit_cnt != WIDTH`: pulse `frame_err`. `data_out` and `data_valid` are unchanged.
  - `bit_cnt == WIDTH` and the holding register is empty, or is being drained this cycle (`data_valid && data_ready`): load `data_out <= shreg` and set `data_valid`.
  - `bit_cnt == WIDTH` and the holding register is full and not drained this cycle: drop the new word, pulse `overrun`, leave `data_out` unchanged.
- `sclk_rise` while in IDLE or WAIT_IDLE is ignored.
- `cs_rise` and `sclk_rise` in the same cycle: the shift happens first and is included in the count, then the frame closes.
- `data_valid` clears on handshake unless a new word loads in that same cycle.

## Timing
- Reset values: `data_out` = 0, `data_valid` = 0, `frame_err` = 0, `overrun` = 0, `busy` = 0. FSM = WAIT_IDLE; shift register and counter = 0.
- Input-to-strobe latency: SYNC_STAGES+1 `clk` edges from a pin transition to its edge strobe.
- `data_valid`, `frame_err` and `overrun` update on the edge that consumes `cs_rise`. That is SYNC_STAGES+2 edges after the `cs` pin rises.
- Minimum legal serial timing:
  - `sclk` high and low phases at least 2 `clk` periods each.
  - `sdo` stable at least 2 `clk` periods around each rising `sclk`.
  - `cs` high at least 2 `clk` periods between frames.
- Reset asserted mid-frame clears all state immediately. After release, the block waits in WAIT_IDLE for `cs` high.

## Structure
- Shared package `spi_pkg`: FSM state enum (WAIT_IDLE, IDLE, RECV), the default-width constant, and the mode-0 edge-select constant, shared with the transmit side.
- Sub-module `sync_bit`: parameterized SYNC_STAGES flop chain with async active-low reset to 0, instantiated three times. The reset value for `cs` is 1.

## Test plan
- Basic frame: send 0xA5C3 at 4 `clk` per `sclk` half-period, `data_ready`=1 → `data_out`=0xA5C3 and `data_valid` high for one cycle, SYNC_STAGES+2 edges after `cs` rises; no error pulses.
- Short and long frames: 15 bits, then 17 bits → `frame_err` pulses once per frame; `data_valid` stays 0 and `data_out` keeps its previous value.
- Backpressure: `data_ready`=0, send 0x0001 then 0x0002 → `data_out`=0x0001 held with one `overrun` pulse. Then raise `data_ready` on the same cycle a third frame 0x0003 closes → 0x0001 is consumed and 0x0003 loads with no overrun.
- Reset mid-frame: assert `rst_n`=0 after 8 bits, release with `cs` still low, finish that frame, then send 0x1234 → first frame ignored; `data_out`=0x1234 with no `frame_err`.
- Idle noise: toggle `sclk` 10 times with `cs` high, then send 0xFFFF → only 0xFFFF is delivered, and `busy` is high only during its frame.
